// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions: handshake FSM states and the
// control-bus layout every IF/ID/EX/MEM/WB stage packs and unpacks.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int PERF_W = 16;

  // Control-bus widths per boundary; all stages share one bit layout.
  localparam int CTRL_W_IFID  = 8;
  localparam int CTRL_W_IDEX  = 8;
  localparam int CTRL_W_EXMEM = 8;
  localparam int CTRL_W_MEMWB = 8;

  localparam int CB_REG_WRITE  = 0;
  localparam int CB_MEM_READ   = 1;
  localparam int CB_MEM_WRITE  = 2;
  localparam int CB_HALT       = 3;
  localparam int CB_MEM_TO_REG = 4;
  localparam int CB_SET_OP     = 5;
  localparam int CB_LINK       = 6;

  function automatic logic [7:0] ctrl_pack(
    input logic reg_write,
    input logic mem_read,
    input logic mem_write,
    input logic halt,
    input logic mem_to_reg,
    input logic set_op,
    input logic link
  );
    logic [7:0] v;
    v                = '0;
    v[CB_REG_WRITE]  = reg_write;
    v[CB_MEM_READ]   = mem_read;
    v[CB_MEM_WRITE]  = mem_write;
    v[CB_HALT]       = halt;
    v[CB_MEM_TO_REG] = mem_to_reg;
    v[CB_SET_OP]     = set_op;
    v[CB_LINK]       = link;
    return v;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// 16-bit saturating event counter with enable; synchronous active-low reset.
module pipe_sat_cnt
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  output logic [PERF_W-1:0] o_cnt
);

  logic [PERF_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {PERF_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline boundary register with optional 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
  parameter int                SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
);

  pipe_state_e       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_m_data, r_s_data;
  logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl;

  logic w_main_vld;
  logic w_acc;
  logic w_emit;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  assign w_main_vld = (r_state != ST_EMPTY);

  // With the skid entry, in_ready depends only on state, breaking the
  // combinational back-pressure chain between stages.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (r_state != ST_FULL);
    end else begin : g_noskid
      assign in_ready = out_ready | ~w_main_vld;
    end
  endgenerate

  assign w_acc  = in_valid & in_ready;
  assign w_emit = w_main_vld & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt  = ST_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && w_emit) begin
          w_ld_main_in = 1'b1;
        end else if (w_acc && (SKID != 0)) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_emit) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_emit) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush kills everything held plus any same-cycle accept.
    if (flush) begin
      w_state_nxt    = ST_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m_data <= '0;
      r_s_data <= '0;
      r_m_ctrl <= CTRL_RST;
      r_s_ctrl <= CTRL_RST;
    end else if (flush) begin
      r_m_ctrl <= CTRL_RST;
      r_s_ctrl <= CTRL_RST;
    end else begin
      if (w_ld_main_in) begin
        r_m_data <= in_data;
        r_m_ctrl <= in_ctrl;
      end else if (w_ld_main_skid) begin
        r_m_data <= r_s_data;
        r_m_ctrl <= r_s_ctrl;
      end
      if (w_ld_skid) begin
        r_s_data <= in_data;
        r_s_ctrl <= in_ctrl;
      end
    end
  end

  assign out_valid = w_main_vld;
  assign out_data  = r_m_data;
  assign out_ctrl  = w_main_vld ? r_m_ctrl : CTRL_RST;

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_en;
  logic w_bubble_en;

  assign w_stall_en  = w_main_vld & ~out_ready;
  assign w_bubble_en = ~w_main_vld & out_ready;

  pipe_sat_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_stall_en),
    .o_cnt (stall_cnt)
  );

  pipe_sat_cnt u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_bubble_en),
    .o_cnt (bubble_cnt)
  );
`else
  assign stall_cnt  = 16'h0000;
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline boundary register that replaces the hand-built per-signal inter-stage registers used between IF/ID/EX/MEM/WB.
- Carries one payload word (DATA_W) plus control bits (CTRL_W) under a valid/ready handshake.
- Optional 2-entry skid buffer registers in_ready, so downstream back-pressure does not propagate combinationally upstream.
- Synchronous flush turns in-flight entries into bubbles whose control bits read as CTRL_RST.

Parameters:
- DATA_W, 16, payload width (ALU result, store value, PC+2, etc. concatenated by instantiator).
- CTRL_W, 8, control width (regWrite, memRead, memWrite, halt, ...); zeroed on bubble.
- CTRL_RST, {CTRL_W{1'b0}}, control value presented for reset/bubble/flush.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, in_ready = out_ready | ~out_valid (combinational).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  kill all held entries this edge.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts (= ~stall).
- out_ctrl  out  CTRL_W  control; CTRL_RST whenever out_valid=0.
- out_data  out  DATA_W  payload; don't-care when out_valid=0.
- stall_cnt  out  16  perf counter (see Optional Feature).
- bubble_cnt  out  16  perf counter (see Optional Feature).

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-low: rst=0 sampled at a rising clk edge resets the block. State EMPTY, out_valid=0, out_ctrl=CTRL_RST, out_data=0, in_ready=1 (after reset edge), counters=0. Reset overrides flush and all handshakes.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Latency 1 cycle, EMPTY to out_valid.
  - No entry dropped or duplicated except by flush.
- SKID=1 FSM, states EMPTY, ONE (main valid), FULL (main+skid valid):
  - EMPTY: accept -> ONE, data into main.
  - ONE, accept & emit: main <= in; stay ONE.
  - ONE, accept & ~emit: in -> skid; go FULL.
  - ONE, ~accept & emit: -> EMPTY.
  - FULL: in_ready=0. On emit: main <= skid; -> ONE.
  - in_ready registered: in_ready = (state != FULL).
  - Order preserved: main is always older than skid.
- SKID=0: single main register, no FULL state. in_ready combinational as stated under Parameters.
- out_valid/out_data/out_ctrl driven from main register only; out_ctrl muxed to CTRL_RST when main invalid.
- Flush:
  - Next state EMPTY; both valids cleared; ctrl registers <= CTRL_RST; data registers hold.
  - A simultaneous accept is discarded.
  - A simultaneous emit still counts downstream (the entry was consumed this cycle).
- Stall (out_ready=0) with EMPTY: no state change. With valid main: out_* held stable (no glitch, no change) until emit.
- Every output is a flop or a flop-fed mux; no combinational path in_* -> out_*. SKID=0 has a path out_ready -> in_ready only.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - bubble_cnt increments each cycle with ~out_valid & out_ready.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset only (not flush).
- Undefined: ports remain, tied to 16'h0000; no counter flops.

Decomposition:
- Shared package pipe_pkg:
  - FSM state typedef (EMPTY/ONE/FULL, 2-bit).
  - Per-stage CTRL_W localparams and bit-index constants for regWrite/memRead/memWrite/halt/memToReg/setOp/link, so stages pack and unpack consistently.
- One sub-module: pipe_sat_cnt (16-bit saturating counter with enable, synchronous active-low reset), instantiated twice under the macro.

Test Plan:
- Reset: rst=0 for 2 edges with in_valid=1, in_ctrl=8'hFF, in_data=16'hBEEF -> out_valid=0, out_ctrl=8'h00, out_data=0. in_ready=1 after rst=1.
- Streaming: out_ready=1, in_data=1..10 back-to-back -> out_data 1..10 on consecutive cycles, 1-cycle latency, in_ready never 0.
- Skid fill: send 16'h0011, 16'h0022 with out_ready=0 -> state FULL, in_ready=0 next cycle, out_data=16'h0011 held. Then out_ready=1 -> 0x0011 then 0x0022 emitted; in_ready=1 again.
- Flush in FULL with simultaneous in_valid (data 16'h0033, ctrl 8'h0F) -> next cycle out_valid=0, out_ctrl=8'h00, in_ready=1. 0x0033 never appears.
- SKID=0 stall: out_ready=0 with main valid -> in_ready=0 in the same cycle, and out_data stable for 5 cycles.
- PIPE_STAGE_PERF_EN: 3 stall cycles then 4 bubble cycles -> stall_cnt=3, bubble_cnt=4. Force 70000 stall cycles -> stall_cnt=16'hFFFF. Without the macro, both counters read 0.
